// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle subtractor computing d = a - b - bin over
// WIDTH bits, DIGIT bits per clock, LSB first. The borrow between digits is
// registered, so the combinational path is only one DIGIT-wide slice.
// A start/done handshake drives it. busy is low in the done cycle, so a new
// request can be accepted there.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the signed
// overflow output ovf. It is updated and held exactly like bor.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             bor,
  output logic             ovf
`else
  output logic             bor
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_subtractor: DIGIT must divide WIDTH and WIDTH must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             brw_r;
  logic [WIDTH-1:0] res_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] d_r;
  logic             bor_r;
  logic             done_r;

  logic [DIGIT:0]         slice_s;
  logic [WIDTH+DIGIT-1:0] res_cat_s;
  logic [WIDTH-1:0]       res_next_s;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf_r;
  logic msb_brw_s;

  // Recover the borrow into the MSB of the final digit. The MSB difference bit is a^b^borrow_in.
  always_comb begin
    msb_brw_s = slice_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
  end

  assign ovf = ovf_r;
`endif

  // One digit of subtraction plus insertion of the new slice at the top of the result.
  always_comb begin
    slice_s    = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_r};
    res_cat_s  = {slice_s[DIGIT-1:0], res_r};
    res_next_s = res_cat_s[WIDTH+DIGIT-1:DIGIT];
  end

  assign busy = (state_r == RUN);
  assign done = done_r;
  assign d    = d_r;
  assign bor  = bor_r;

  // Control FSM and datapath registers; d/bor only move on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      brw_r   <= 1'b0;
      res_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      bor_r   <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            brw_r   <= bin;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          brw_r <= slice_s[DIGIT];
          res_r <= res_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            d_r     <= res_next_s;
            bor_r   <= slice_s[DIGIT];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r   <= msb_brw_s ^ slice_s[DIGIT];
`endif
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: three instances (W8/D1, W8/D4, W2/D1) checked every
// cycle against a transaction-level model, plus directed vectors with
// hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] st = 3'b000;
  logic [7:0] av [3];
  logic [7:0] bv [3];
  logic [2:0] bi = 3'b000;
  logic [2:0] busy_o, done_o, bor_o;
  logic [7:0] d0, d1;
  logic [1:0] d2;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic [2:0] ovf_o;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .bin(bi[0]),
    .busy(busy_o[0]), .done(done_o[0]), .d(d0),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_o[0]),
`endif
    .bor(bor_o[0]));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]), .bin(bi[1]),
    .busy(busy_o[1]), .done(done_o[1]), .d(d1),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_o[1]),
`endif
    .bor(bor_o[1]));

  serial_subtractor #(.WIDTH(2), .DIGIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][1:0]), .b(bv[2][1:0]), .bin(bi[2]),
    .busy(busy_o[2]), .done(done_o[2]), .d(d2),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .ovf(ovf_o[2]),
`endif
    .bor(bor_o[2]));

  function automatic logic [7:0] dval(input int i);
    case (i)
      0:       dval = d0;
      1:       dval = d1;
      default: dval = {6'd0, d2};
    endcase
  endfunction

  function automatic int wid(input int i);
    wid = (i == 2) ? 2 : 8;
  endfunction

  function automatic int ndig(input int i);
    case (i)
      0:       ndig = 8;
      1:       ndig = 2;
      default: ndig = 2;
    endcase
  endfunction

  // Reference arithmetic: plain integer subtraction over the instance width
  function automatic int ref_r(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    int m;
    m = (1 << w) - 1;
    ref_r = (int'(a) & m) - (int'(b) & m) - int'(bin);
  endfunction

  function automatic logic ref_ovf(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    int m, sa, sb, r;
    m  = (1 << w) - 1;
    sa = int'(a) & m;
    sb = int'(b) & m;
    if (sa >= (1 << (w - 1))) sa = sa - (1 << w);
    if (sb >= (1 << (w - 1))) sb = sb - (1 << w);
    r = sa - sb - int'(bin);
    ref_ovf = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
  endfunction

  // Transaction model state
  logic [2:0] mbusy, mdone, mbor, mpb, mo, mpo;
  logic [7:0] md [3];
  logic [7:0] mpd [3];
  int         mcnt [3];

  // Model: accept when idle, deliver the result N edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 3'b000; mdone <= 3'b000; mbor <= 3'b000; mpb <= 3'b000;
      mo <= 3'b000; mpo <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        md[i] <= 8'd0; mpd[i] <= 8'd0; mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        mdone[i] <= 1'b0;
        if (!mbusy[i]) begin
          if (st[i]) begin
            mpd[i]   <= 8'(ref_r(wid(i), av[i], bv[i], bi[i]) & ((1 << wid(i)) - 1));
            mpb[i]   <= (ref_r(wid(i), av[i], bv[i], bi[i]) < 0);
            mpo[i]   <= ref_ovf(wid(i), av[i], bv[i], bi[i]);
            mcnt[i]  <= ndig(i);
            mbusy[i] <= 1'b1;
          end
        end else begin
          mcnt[i] <= mcnt[i] - 1;
          if (mcnt[i] == 1) begin
            mbusy[i] <= 1'b0;
            mdone[i] <= 1'b1;
            md[i]    <= mpd[i];
            mbor[i]  <= mpb[i];
            mo[i]    <= mpo[i];
          end
        end
      end
    end
  end

  // Compare process: every output of every instance on each falling edge
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      for (int i = 0; i < 3; i++) begin
        checks = checks + 4;
        if (busy_o[i] !== mbusy[i]) begin
          errors++; $display("FAIL model_busy u%0d t=%0t got %b exp %b", i, $time, busy_o[i], mbusy[i]);
        end
        if (done_o[i] !== mdone[i]) begin
          errors++; $display("FAIL model_done u%0d t=%0t got %b exp %b", i, $time, done_o[i], mdone[i]);
        end
        if (dval(i) !== md[i]) begin
          errors++; $display("FAIL model_d u%0d t=%0t got %h exp %h", i, $time, dval(i), md[i]);
        end
        if (bor_o[i] !== mbor[i]) begin
          errors++; $display("FAIL model_bor u%0d t=%0t got %b exp %b", i, $time, bor_o[i], mbor[i]);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        checks++;
        if (ovf_o[i] !== mo[i]) begin
          errors++; $display("FAIL model_ovf u%0d t=%0t got %b exp %b", i, $time, ovf_o[i], mo[i]);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Issue one request from a falling edge and wait (bounded) for its done pulse
  task automatic run(input int i, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] exp_d, input logic exp_bor, input int exp_lat, input int exp_busy);
    int k, bc;
    st[i] = 1'b1; av[i] = a; bv[i] = b; bi[i] = bin;
    @(negedge clk);
    st[i] = 1'b0; av[i] = 8'h00; bv[i] = 8'h00; bi[i] = 1'b0;
    k = 0; bc = 0;
    while (!done_o[i] && k < 50) begin
      if (busy_o[i]) bc++;
      @(negedge clk);
      k++;
    end
    chk($sformatf("latency_u%0d", i), k + 1, exp_lat);
    if (exp_busy > 0) chk($sformatf("busy_cycles_u%0d", i), bc, exp_busy);
    chk($sformatf("d_u%0d_%h_%h_%b", i, a, b, bin), int'(dval(i)), int'(exp_d));
    chk($sformatf("bor_u%0d_%h_%h_%b", i, a, b, bin), int'(bor_o[i]), int'(exp_bor));
  endtask

  initial begin
    int dn;
    logic [1:0] ea;
    for (int i = 0; i < 3; i++) begin av[i] = 8'h00; bv[i] = 8'h00; end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy_u%0d", i), int'(busy_o[i]), 0);
      chk($sformatf("reset_done_u%0d", i), int'(done_o[i]), 0);
      chk($sformatf("reset_d_u%0d", i), int'(dval(i)), 0);
      chk($sformatf("reset_bor_u%0d", i), int'(bor_o[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // W8/D1 directed vectors, then back-to-back start in the done cycle
    run(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 9, 8);
    run(0, 8'hC8, 8'h37, 1'b0, 8'h91, 1'b0, 9, 8);
    run(0, 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 9, 8);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 9, 8);
    chk("ovf_80_01", int'(ovf_o[0]), 1);
    run(0, 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 9, 8);
    chk("ovf_7f_01", int'(ovf_o[0]), 0);
`endif

    // W8/D4 and the full W2/D1 sweep
    run(1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 3, 2);
    run(1, 8'h3C, 8'hA5, 1'b0, 8'h97, 1'b1, 3, 2);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int z = 0; z < 2; z++) begin
          ea = 2'(x - y - z);
          run(2, 8'(x), 8'(y), 1'(z), {6'd0, ea}, (x < y + z), 3, 2);
        end

    // Start while busy is ignored; exactly one done pulse
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h05; bv[0] = 8'h03; bi[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'h00;
    @(negedge clk);
    st[0] = 1'b0; av[0] = 8'h00;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o[0]) begin
        dn++;
        chk("ignored_start_d", int'(d0), 8'h02);
        chk("ignored_start_bor", int'(bor_o[0]), 0);
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", dn, 1);

    // Reset in the 4th RUN cycle of an operation
    st[0] = 1'b1; av[0] = 8'h12; bv[0] = 8'h34; bi[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy_o[0]), 0);
    chk("midreset_done", int'(done_o[0]), 0);
    chk("midreset_d", int'(d0), 0);
    chk("midreset_bor", int'(bor_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_o[0]) dn++;
      @(negedge clk);
    end
    chk("midreset_no_done", dn, 0);
    run(0, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 9, 8);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor. Computes d = a - b - bin over WIDTH bits, DIGIT bits per clock, LSB first. The borrow chain is registered between digits, extending the team's half/full subtractor cells to wide operands without a long combinational borrow path. It sits beside the combinational arithmetic cells and is driven by a start/done handshake from a controller.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only while busy=0.
a  input  WIDTH  minuend; sampled at the accepting edge only.
b  input  WIDTH  subtrahend; sampled at the accepting edge only.
bin  input  1  borrow-in; sampled at the accepting edge only.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse; d and bor are valid from this cycle.
d  output  WIDTH  difference, held until the next completion.
bor  output  1  borrow-out (1 when a < b + bin, unsigned), held like d.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, done, bor=0; d=0; digit counter=0; internal shift registers=0.
- States:
  - IDLE: busy=0. If start=1 at an edge:
    - latch a, b, bin into internal operand and borrow registers;
    - clear counter;
    - go to RUN.
  - RUN: busy=1. At each edge:
    - take the low DIGIT bits of the operand registers plus the borrow register;
    - compute slice = a_dig - b_dig - borrow as DIGIT+1 bits; new borrow = bit DIGIT of the result;
    - shift operands right by DIGIT; shift the result slice into the result register from the top;
    - increment counter.
  - Last digit (counter = N-1, N = WIDTH/DIGIT):
    - copy the final result to d and the final borrow to bor;
    - set done=1 for the next cycle;
    - return to IDLE.
- Latency: the start-accepting edge is E. Digits are processed at edges E+1..E+N. done is high during the cycle after edge E+N.
  - WIDTH=8, DIGIT=1: 9 edges from acceptance to the done pulse.
- Back-to-back operation: busy=0 while done=1, so a start in the done cycle is accepted. Throughput is one result per N+1 cycles.
- start while busy=1 is ignored and does not queue. Changing a/b/bin while busy has no effect.
- d and bor change only at a completion edge. They are never partially updated during RUN.
- Reset mid-operation: the in-flight operation is discarded, no done pulse is produced, and d/bor return to 0.
- WIDTH=DIGIT (N=1): a single RUN cycle; still registered, latency 2 edges.
- All arithmetic is modulo 2^WIDTH. bor equals the carry-inverted result of the equivalent full-width subtraction.

Optional Feature:
Macro SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), reset 0, updated and held exactly like bor;
  - ovf=1 when the signed two's-complement result of a - b - bin is not representable in WIDTH bits;
  - computed as (final borrow into MSB) XOR (borrow out of MSB).
- Undefined: the port and its logic are absent. Remaining behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> d=0xFF, bor=1; done exactly 9 edges after acceptance; busy high for 8 cycles.
- WIDTH=8, DIGIT=1: a=0xC8, b=0x37, bin=0 -> d=0x91, bor=0. Then a start pulsed in the done cycle with a=0x5A, b=0x5A, bin=1 -> accepted; d=0xFF, bor=1.
- WIDTH=8, DIGIT=4: a=0x10, b=0x01, bin=1 -> d=0x0E, bor=0; done 3 edges after acceptance. Also sweep all 2^(2+2+1) inputs at WIDTH=2, DIGIT=1 against a reference model.
- WIDTH=8, DIGIT=1: start with a=0x05, b=0x03, then start again with a=0xFF, b=0x00 at the 3rd busy cycle -> second request ignored; d=0x02, bor=0; single done pulse.
- Reset mid-operation: assert rst_n=0 at the 4th RUN cycle -> busy, done, d, bor go to 0 immediately; no done pulse after release; a subsequent start completes normally.
- SERIAL_SUBTRACTOR_OVF_EN defined, WIDTH=8:
  - a=0x80, b=0x01, bin=0 -> d=0x7F, ovf=1, bor=0;
  - a=0x7F, b=0x01 -> d=0x7E, ovf=0.
